// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: encoder state encoding, line-pair constants
// ({dp,dm}) and default framing parameters.
package usb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_STUFF,
      ST_EOP_SE0,
      ST_EOP_J
   } state_t;

   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam int SYNC_BITS_DEF   = 8;
   localparam int STUFF_LIMIT_DEF = 6;

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI level tracker: a 0 flips the line level, a 1 holds it. lvl is the level
// for the bit presented this cycle (1 = J, 0 = K); load_j re-arms to J.
module usb_nrzi_enc (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   input  logic load_j,
   output logic lvl
);

   logic lvl_q;

   always_comb begin
      lvl = lvl_q;
      if (load_j)
         lvl = 1'b1;
      else if (en && !din)
         lvl = ~lvl_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lvl_q <= 1'b1;
      else
         lvl_q <= lvl;
   end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line encoder: SYNC, bit-stuffed payload, EOP.
// Define USB_TX_NRZI_EN to NRZI-encode the bit stream; otherwise dp=bit, dm=~bit.
module usb_tx_line_encoder
   import usb_pkg::*;
#(
   parameter int SYNC_BITS   = SYNC_BITS_DEF,
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bit_in,
   input  logic bit_valid,
   input  logic bit_last,
   output logic bit_ready,
   output logic dp,
   output logic dm,
   output logic busy,
   output logic done,
   output logic underrun
);

   localparam int SC_W = $clog2(SYNC_BITS + 1);
   localparam int OW   = $clog2(STUFF_LIMIT + 1);
   localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_BITS - 1);
   localparam logic [OW-1:0]   LIMIT     = OW'(STUFF_LIMIT);

   state_t          state_q, state_d;
   logic [SC_W-1:0] sync_cnt_q, sync_cnt_d;
   logic [OW-1:0]   ones_q, ones_d, ones_inc;
   logic            eop_cnt_q, eop_cnt_d;
   logic            last_pend_q, last_pend_d;
   logic            abort_q, abort_d;
   logic            done_q;

   // What gets driven onto the line in the next cycle
   logic            emit_bit, raw_bit, emit_se0, emit_j;
   logic [1:0]      bit_line, line_d;

   assign ones_inc = ones_q + OW'(1);

   always_comb begin
      state_d     = state_q;
      sync_cnt_d  = sync_cnt_q;
      ones_d      = ones_q;
      eop_cnt_d   = eop_cnt_q;
      last_pend_d = last_pend_q;
      abort_d     = abort_q;
      emit_bit    = 1'b0;
      raw_bit     = 1'b0;
      emit_se0    = 1'b0;
      emit_j      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            emit_j = 1'b1;
            if (start) begin
               // First SYNC bit leaves with the transition itself
               state_d     = ST_SYNC;
               emit_j      = 1'b0;
               emit_bit    = 1'b1;
               sync_cnt_d  = SC_W'(1);
               ones_d      = '0;
               abort_d     = 1'b0;
               last_pend_d = 1'b0;
            end
         end
         ST_SYNC: begin
            emit_bit   = 1'b1;
            raw_bit    = (sync_cnt_q == SYNC_LAST);
            ones_d     = raw_bit ? ones_inc : '0;
            sync_cnt_d = sync_cnt_q + SC_W'(1);
            if (raw_bit)
               state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_valid) begin
               emit_bit = 1'b1;
               raw_bit  = bit_in;
               ones_d   = bit_in ? ones_inc : '0;
               if (bit_in && ones_inc == LIMIT) begin
                  state_d     = ST_STUFF;
                  last_pend_d = bit_last;
               end else if (bit_last) begin
                  state_d   = ST_EOP_SE0;
                  eop_cnt_d = 1'b0;
               end
            end else begin
               // Starved: this cycle already supplies the first SE0
               emit_se0  = 1'b1;
               state_d   = ST_EOP_SE0;
               eop_cnt_d = 1'b1;
               abort_d   = 1'b1;
            end
         end
         ST_STUFF: begin
            emit_bit = 1'b1;
            ones_d   = '0;
            if (last_pend_q) begin
               state_d   = ST_EOP_SE0;
               eop_cnt_d = 1'b0;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_EOP_SE0: begin
            emit_se0 = 1'b1;
            if (eop_cnt_q)
               state_d = ST_EOP_J;
            else
               eop_cnt_d = 1'b1;
         end
         ST_EOP_J: begin
            emit_j  = 1'b1;
            ones_d  = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef USB_TX_NRZI_EN
   logic lvl;

   usb_nrzi_enc u_nrzi (
      .clk    (clk),
      .rst    (rst),
      .en     (emit_bit),
      .din    (raw_bit),
      .load_j (emit_j | emit_se0),
      .lvl    (lvl)
   );

   assign bit_line = lvl ? LINE_J : LINE_K;
`else
   assign bit_line = {raw_bit, ~raw_bit};
`endif

   assign line_d = emit_se0 ? LINE_SE0 : (emit_bit ? bit_line : LINE_J);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sync_cnt_q  <= '0;
         ones_q      <= '0;
         eop_cnt_q   <= 1'b0;
         last_pend_q <= 1'b0;
         abort_q     <= 1'b0;
         done_q      <= 1'b0;
         {dp, dm}    <= LINE_J;
      end else begin
         state_q     <= state_d;
         sync_cnt_q  <= sync_cnt_d;
         ones_q      <= ones_d;
         eop_cnt_q   <= eop_cnt_d;
         last_pend_q <= last_pend_d;
         abort_q     <= abort_d;
         done_q      <= (state_q == ST_EOP_J) && !abort_q;
         {dp, dm}    <= line_d;
      end
   end

   assign bit_ready = (state_q == ST_DATA);
   assign busy      = (state_q != ST_IDLE);
   assign underrun  = (state_q == ST_DATA) && !bit_valid;
   assign done      = done_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder: packet table plus reset and
// back-to-back sequences; expected line pairs are queued as packets are driven.
module tb_usb_tx_line_encoder;

   localparam int SB = 8;
   localparam int SL = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, bit_last = 1'b0;
   logic bit_ready, dp, dm, busy, done, underrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [1:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      int         n;
      int         drop;
      int         npkt;
      bit         hold;
      int         exp_done;
      int         exp_und;
      string      name;
   } vec_t;

   vec_t tbl[7];

   usb_tx_line_encoder #(.SYNC_BITS(SB), .STUFF_LIMIT(SL)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_last  (bit_last),
      .bit_ready (bit_ready),
      .dp        (dp),
      .dm        (dm),
      .busy      (busy),
      .done      (done),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input int n, input int drop,
                               input int npkt, input bit hold, input int ed,
                               input int eu, input string nm);
      vec_t v;
      v.data = d; v.n = n; v.drop = drop; v.npkt = npkt; v.hold = hold;
      v.exp_done = ed; v.exp_und = eu; v.name = nm;
      return v;
   endfunction

   // Reference stream: SYNC, payload with a 0 after every SL ones, 2 SE0, J
   task automatic build(input logic [7:0] data, input int n, input int drop,
                        output int len, output int gaps);
      bit raw[$];
      int ones = 0;
      int nsend = (drop >= 0) ? drop : n;
      bit b;
      bit lvl = 1'b1;
      gaps = 0;
      for (int i = 0; i < SB; i++) begin
         b = (i == SB - 1);
         raw.push_back(b);
         ones = b ? ones + 1 : 0;
      end
      for (int i = 0; i < nsend; i++) begin
         b = data[i];
         raw.push_back(b);
         ones = b ? ones + 1 : 0;
         if (ones == SL) begin
            raw.push_back(1'b0);
            ones = 0;
            if (drop >= 0 || i < nsend - 1) gaps++;
         end
      end
      len = raw.size() + 3;
      foreach (raw[i]) begin
`ifdef USB_TX_NRZI_EN
         if (!raw[i]) lvl = ~lvl;
         exp_q.push_back(lvl ? 2'b10 : 2'b01);
`else
         lvl = raw[i];
         exp_q.push_back({lvl, ~lvl});
`endif
      end
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b10);
   endtask

   task automatic run_vec(input vec_t v);
      int len, gaps, idx, rdy, first_rdy, gap_cnt, pend, dn, un;
      bit in_data;
      logic [1:0] el;
      exp_q.delete();
      for (int p = 0; p < v.npkt; p++) build(v.data, v.n, v.drop, len, gaps);
      idx = 0; rdy = 0; first_rdy = -1; gap_cnt = 0; pend = 0; dn = 0; un = 0;
      in_data = 1'b0;
      for (int cyc = 0; cyc < len * v.npkt + 2; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0) || (v.hold && cyc < v.npkt * len);
         bit_valid = !(v.drop >= 0 && idx >= v.drop);
         bit_in    = v.data[idx];
         bit_last  = (idx == v.n - 1);
         #1;
         el = (cyc >= 1 && exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
         chk({v.name, " line"}, {dp, dm}, el);
         chk({v.name, " busy"}, busy, (cyc % len != 0) && cyc < v.npkt * len);
         chk({v.name, " done"}, done,
             (v.drop < 0) && cyc > 0 && cyc % len == 0 && cyc <= v.npkt * len);
         chk({v.name, " underrun"}, underrun, (v.drop >= 0) && cyc == len - 3);
         if (done) dn++;
         if (underrun) un++;
         if (bit_ready) begin
            rdy++;
            if (first_rdy < 0) first_rdy = cyc;
            if (in_data) gap_cnt += pend;
            pend = 0;
            in_data = 1'b1;
         end else if (in_data && busy) begin
            pend++;
         end
         if (!busy) begin
            in_data = 1'b0;
            pend = 0;
         end
         if (bit_ready && bit_valid) idx = (idx + 1) % v.n;
      end
      start = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
      chk({v.name, " done count"}, dn, v.exp_done);
      chk({v.name, " underrun count"}, un, v.exp_und);
      chk({v.name, " ready cycles"}, rdy, (v.drop >= 0) ? v.drop + 1 : v.n * v.npkt);
      chk({v.name, " first ready"}, first_rdy, SB);
      chk({v.name, " stuff gaps"}, gap_cnt, gaps * v.npkt);
   endtask

   initial begin
      tbl[0] = mk(8'hA5, 8, -1, 1, 1'b0, 1, 0, "a5");
      tbl[1] = mk(8'hFF, 8, -1, 1, 1'b0, 1, 0, "ff_stuff");
      tbl[2] = mk(8'h3F, 6, -1, 1, 1'b0, 1, 0, "six_ones");
      tbl[3] = mk(8'h1F, 5, -1, 1, 1'b0, 1, 0, "stuff_on_last");
      tbl[4] = mk(8'hA5, 8, 3, 1, 1'b0, 0, 1, "underrun");
      tbl[5] = mk(8'h00, 8, -1, 1, 1'b0, 1, 0, "zeros");
      tbl[6] = mk(8'hA5, 8, -1, 2, 1'b1, 2, 0, "back_to_back");

      // Reset state
      @(negedge clk);
      #1;
      chk("reset line", {dp, dm}, 2'b10);
      chk("reset busy", busy, 1'b0);
      chk("reset ready", bit_ready, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset underrun", underrun, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("idle after reset", {busy, dp, dm}, 3'b010);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset mid-DATA: line snaps to J at once, packet is abandoned
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         start = (cyc == 0);
         bit_valid = 1'b1;
         bit_in = 1'b1;
         bit_last = 1'b0;
      end
      #1;
      chk("pre-reset busy", busy, 1'b1);
      chk("pre-reset ready", bit_ready, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid reset line", {dp, dm}, 2'b10);
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset ready", bit_ready, 1'b0);
      chk("mid reset underrun", underrun, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bit_valid = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         #1;
         chk("post reset idle line", {dp, dm}, 2'b10);
         chk("post reset busy", busy, 1'b0);
         chk("post reset done", done, 1'b0);
      end
      run_vec(tbl[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
